// File: rtl/adder_pg_sum_pipe.sv
// Two-stage G/P-in, carry-in, sum-out shell around an external prefix carry network; ADDER_PG_SUB_EN adds subtract.
// Latency: result valid one edge after the accept edge; holds 2 beats, in_ready falls when both stages are full and out_ready is low.
module adder_pg_sum_pipe #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_cin,
`ifdef ADDER_PG_SUB_EN
  input  logic         in_sub,
`endif
  output logic [N:0]   pg_g,
  output logic [N:1]   pg_p,
  input  logic [N:0]   pg_c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         out_zero
);

  logic         r_s1_valid;
  logic         r_s2_valid;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic         r_cin;
  logic [N-1:0] r_sum;
  logic         r_cout;
  logic         r_ovf;
  logic         r_zero;

  logic         w_sub;
  logic         w_s2_free;
  logic         w_accept;
  logic         w_advance;
  logic [N-1:0] w_b_eff;
  logic [N-1:0] w_sum;

  assign w_s2_free = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign w_accept  = in_valid && in_ready;
  assign w_advance = r_s1_valid && w_s2_free;

`ifdef ADDER_PG_SUB_EN
  logic r_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sub <= 1'b0;
    end else if (w_accept) begin
      r_sub <= in_sub;
    end
  end

  assign w_sub = r_sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtract is A + ~B + 1: invert B and force the carry-in, ignoring cin.
  assign w_b_eff = r_b ^ {N{w_sub}};
  assign pg_g    = {r_a & w_b_eff, r_cin | w_sub};
  assign pg_p    = r_a ^ w_b_eff;

  assign w_sum   = pg_p ^ pg_c[N-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_cin      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= in_a;
        r_b   <= in_b;
        r_cin <= in_cin;
      end
      if (w_accept) begin
        r_s1_valid <= 1'b1;
      end else if (w_advance) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2 only reloads when free, so outputs hold steady under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_advance) begin
      r_s2_valid <= 1'b1;
      r_sum      <= w_sum;
      r_cout     <= pg_c[N];
      r_ovf      <= pg_c[N] ^ pg_c[N-1];
      r_zero     <= ~|w_sum;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
  assign out_zero  = r_zero;

endmodule
